// File: rtl/softmax_max_buffer.sv
// softmax_max_buffer
// Captures one softmax vector of NUMBER_OF_DATA float words while tracking the
// running maximum, then replays the words in arrival order together with the
// final maximum to the downstream subtract/exp stage under ready/valid control.
//
// Ports
//   clock_i      : clock, rising edge
//   reset_i      : synchronous active-high reset
//   start_i      : data_i holds a valid input word this cycle
//   data_i       : input float word
//   ready_i      : downstream accepts data_o this cycle
//   data_valid_o : data_o / max_o valid for downstream
//   data_o       : buffered word, replayed in arrival order
//   max_o        : maximum of the current vector
//   busy_o       : FSM is not IDLE
//   done_o       : one-cycle pulse after the last word is accepted
//   error_o      : sticky NaN/Inf seen in the current vector
//
// Optional feature: define SOFTMAX_MAX_BUFFER_NAN_DETECT_EN to enable error_o
// (exponent 8'hFF detection); otherwise error_o is held at 0.
module softmax_max_buffer #(
    parameter int unsigned DATA_SIZE      = 32,
    parameter int unsigned NUMBER_OF_DATA = 10
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 ready_i,
    output logic                 data_valid_o,
    output logic [DATA_SIZE-1:0] data_o,
    output logic [DATA_SIZE-1:0] max_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int unsigned CW = $clog2(NUMBER_OF_DATA + 1);
    localparam int unsigned AW = (NUMBER_OF_DATA > 1) ? $clog2(NUMBER_OF_DATA) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUMBER_OF_DATA - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_REPLAY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state, w_state_next;
    logic [DATA_SIZE-1:0]  r_buf [NUMBER_OF_DATA];
    logic [CW-1:0]         r_count, w_count_next;
    logic [CW-1:0]         r_rd_ptr, w_rd_ptr_next, w_rd_inc;
    logic [DATA_SIZE-1:0]  r_max_run, w_max_run_next, w_max_upd;
    logic [DATA_SIZE-1:0]  r_max, w_max_next;
    logic [DATA_SIZE-1:0]  r_data, w_data_next;
    logic                  r_valid, w_valid_next;
    logic                  r_busy, w_busy_next;
    logic                  r_done, w_done_next;
    logic                  r_error, w_error_next;
    logic                  w_wr_en;
    logic [AW-1:0]         w_wr_addr;

    // Sign-magnitude "a strictly greater than b"; +0 and -0 compare equal so
    // a tie never replaces the earlier word.
    function automatic logic f_greater(input logic [DATA_SIZE-1:0] a,
                                       input logic [DATA_SIZE-1:0] b);
        logic [DATA_SIZE-2:0] ma;
        logic [DATA_SIZE-2:0] mb;
        ma = a[DATA_SIZE-2:0];
        mb = b[DATA_SIZE-2:0];
        if ((ma == '0) && (mb == '0)) return 1'b0;
        if (a[DATA_SIZE-1] != b[DATA_SIZE-1]) return ~a[DATA_SIZE-1];
        if (!a[DATA_SIZE-1]) return (ma > mb);
        return (ma < mb);
    endfunction

`ifdef SOFTMAX_MAX_BUFFER_NAN_DETECT_EN
    function automatic logic f_exp_ff(input logic [DATA_SIZE-1:0] a);
        return (a[DATA_SIZE-2 -: 8] == 8'hFF);
    endfunction
`endif

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_max_run <= '0;
            r_max     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_rd_ptr  <= w_rd_ptr_next;
            r_max_run <= w_max_run_next;
            r_max     <= w_max_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_error   <= w_error_next;
        end
    end

    // Word storage; contents are don't-care after reset.
    always_ff @(posedge clock_i) begin
        if (w_wr_en) r_buf[w_wr_addr] <= data_i;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start_i) w_state_next = S_LOAD;
            S_LOAD:   if (start_i && (r_count == LAST_IDX)) w_state_next = S_REPLAY;
            S_REPLAY: if (r_valid && ready_i && (r_rd_ptr == LAST_IDX)) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath and next output values.
    always_comb begin
        w_wr_en        = 1'b0;
        w_wr_addr      = '0;
        w_count_next   = r_count;
        w_rd_ptr_next  = r_rd_ptr;
        w_max_run_next = r_max_run;
        w_max_next     = r_max;
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_done_next    = 1'b0;
        w_error_next   = r_error;
        w_rd_inc       = r_rd_ptr + CW'(1);
        w_max_upd      = f_greater(data_i, r_max_run) ? data_i : r_max_run;

        unique case (r_state)
            S_IDLE: begin
                w_valid_next = 1'b0;
                if (start_i) begin
                    w_wr_en        = 1'b1;
                    w_max_run_next = data_i;
                    w_count_next   = CW'(1);
                end
            end
            S_LOAD: begin
                if (start_i) begin
                    w_wr_en        = 1'b1;
                    w_wr_addr      = AW'(r_count);
                    w_max_run_next = w_max_upd;
                    w_count_next   = r_count + CW'(1);
                    // Last word: publish the final max and the first replay word together.
                    if (r_count == LAST_IDX) begin
                        w_max_next    = w_max_upd;
                        w_valid_next  = 1'b1;
                        w_data_next   = r_buf[0];
                        w_rd_ptr_next = '0;
                    end
                end
            end
            S_REPLAY: begin
                if (r_valid && ready_i) begin
                    if (r_rd_ptr == LAST_IDX) begin
                        w_valid_next = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_rd_ptr_next = w_rd_inc;
                        w_data_next   = r_buf[AW'(w_rd_inc)];
                    end
                end
            end
            S_DONE: begin
                w_valid_next  = 1'b0;
                w_count_next  = '0;
                w_rd_ptr_next = '0;
            end
            default: ;
        endcase

`ifdef SOFTMAX_MAX_BUFFER_NAN_DETECT_EN
        // Sticky within a vector; the first word of a new vector restarts it.
        if ((r_state == S_IDLE) && start_i)
            w_error_next = f_exp_ff(data_i);
        else if (w_wr_en)
            w_error_next = r_error | f_exp_ff(data_i);
`else
        w_error_next = 1'b0;
`endif

        w_busy_next = (w_state_next != S_IDLE);
    end

    assign data_valid_o = r_valid;
    assign data_o       = r_data;
    assign max_o        = r_max;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;

endmodule

// File: tb/tb_softmax_max_buffer.sv
// Directed testbench for softmax_max_buffer: a 10-word instance and a 4-word
// instance share clock and reset; each scenario task checks its own results.
module tb_softmax_max_buffer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start10, ready10, valid10, busy10, done10, err10;
    logic [31:0] data10, dout10, max10;
    logic        start4, ready4, valid4, busy4, done4, err4;
    logic [31:0] data4, dout4, max4;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] MAX10 = 32'h41A0ED91;
`ifdef SOFTMAX_MAX_BUFFER_NAN_DETECT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic [31:0] w10 [10] = '{32'h40AB0A3D, 32'h418A49BA, 32'h4158C8B4, 32'h41A0ED91,
                              32'h40B5FBE7, 32'h40FE872B, 32'h41035810, 32'h4166B020,
                              32'h4184126E, 32'h3E1CAC08};
    logic [31:0] cur10 [10];
    logic [31:0] cur4 [4];

    softmax_max_buffer #(.DATA_SIZE(32), .NUMBER_OF_DATA(10)) u_dut10 (
        .clock_i(clk), .reset_i(rst), .start_i(start10), .data_i(data10),
        .ready_i(ready10), .data_valid_o(valid10), .data_o(dout10), .max_o(max10),
        .busy_o(busy10), .done_o(done10), .error_o(err10));

    softmax_max_buffer #(.DATA_SIZE(32), .NUMBER_OF_DATA(4)) u_dut4 (
        .clock_i(clk), .reset_i(rst), .start_i(start4), .data_i(data4),
        .ready_i(ready4), .data_valid_o(valid4), .data_o(dout4), .max_o(max4),
        .busy_o(busy4), .done_o(done4), .error_o(err4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive cur10[from..to] back to back, then release start.
    task automatic load10(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            start10 = 1'b1;
            data10  = cur10[i];
            tick();
        end
        start10 = 1'b0;
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) begin
            start4 = 1'b1;
            data4  = cur4[i];
            tick();
        end
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start10 = 1'b1; ready10 = 1'b1; data10 = 32'h3F800000;
        start4 = 1'b1; ready4 = 1'b1; data4 = 32'h3F800000;
        tick(); tick();
        n_checks++; if ({valid10, busy10, done10, err10} !== 4'b0) begin n_errors++; $display("FAIL reset_flags10: got %b required 0000", {valid10, busy10, done10, err10}); end
        n_checks++; if ({dout10, max10} !== 64'h0) begin n_errors++; $display("FAIL reset_data10: got %h %h required 0 0", dout10, max10); end
        n_checks++; if ({valid4, busy4, done4, err4, dout4, max4} !== 68'h0) begin n_errors++; $display("FAIL reset_dut4: got %b %h %h required all 0", {valid4, busy4, done4, err4}, dout4, max4); end
        rst = 1'b0; start10 = 1'b0; start4 = 1'b0;
        tick();
        n_checks++; if (busy10 !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy: got %b required 0", busy10); end
    endtask

    task automatic test_basic();
        int idx = 0;
        int cyc = 0;
        cur10 = w10; ready10 = 1'b1;
        load10(0, 9);
        n_checks++; if (valid10 !== 1'b1) begin n_errors++; $display("FAIL basic_valid_latency: got %b required 1", valid10); end
        n_checks++; if (max10 !== MAX10) begin n_errors++; $display("FAIL basic_max: got %h required %h", max10, MAX10); end
        while (idx < 10 && cyc < 30) begin
            n_checks++; if (valid10 !== 1'b1 || dout10 !== cur10[idx]) begin n_errors++; $display("FAIL basic_replay[%0d]: got v=%b %h required v=1 %h", idx, valid10, dout10, cur10[idx]); end
            idx++; cyc++; tick();
        end
        n_checks++; if (cyc !== 10) begin n_errors++; $display("FAIL basic_replay_cycles: got %0d required 10", cyc); end
        n_checks++; if (done10 !== 1'b1 || valid10 !== 1'b0) begin n_errors++; $display("FAIL basic_done: got done=%b v=%b required done=1 v=0", done10, valid10); end
        tick();
        n_checks++; if (done10 !== 1'b0 || busy10 !== 1'b0) begin n_errors++; $display("FAIL basic_idle: got done=%b busy=%b required 0 0", done10, busy10); end
        n_checks++; if (dout10 !== cur10[9] || max10 !== MAX10) begin n_errors++; $display("FAIL basic_idle_hold: got %h %h required %h %h", dout10, max10, cur10[9], MAX10); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        int hold2 = 0;
        cur10 = w10; ready10 = 1'b1;
        load10(0, 9);
        while (idx < 10 && cyc < 40) begin
            n_checks++; if (valid10 !== 1'b1 || dout10 !== cur10[idx] || max10 !== MAX10) begin n_errors++; $display("FAIL bp_replay[%0d]: got v=%b %h max %h required v=1 %h max %h", idx, valid10, dout10, max10, cur10[idx], MAX10); end
            if (dout10 === cur10[2]) hold2++;
            if (idx == 2 && stall < 3) begin ready10 = 1'b0; stall++; end
            else begin ready10 = 1'b1; idx++; end
            cyc++; tick();
        end
        ready10 = 1'b1;
        n_checks++; if (cyc !== 13) begin n_errors++; $display("FAIL bp_total_cycles: got %0d required 13", cyc); end
        n_checks++; if (hold2 !== 4) begin n_errors++; $display("FAIL bp_hold_word2: got %0d required 4", hold2); end
        n_checks++; if (done10 !== 1'b1) begin n_errors++; $display("FAIL bp_done: got %b required 1", done10); end
        tick();
    endtask

    task automatic test_gapped();
        int idx = 0;
        cur10 = w10; ready10 = 1'b1;
        load10(0, 3);
        for (int g = 0; g < 2; g++) begin
            n_checks++; if (valid10 !== 1'b0 || busy10 !== 1'b1) begin n_errors++; $display("FAIL gap_hold[%0d]: got v=%b busy=%b required 0 1", g, valid10, busy10); end
            tick();
        end
        load10(4, 8);
        n_checks++; if (valid10 !== 1'b0) begin n_errors++; $display("FAIL gap_early_valid: got %b required 0", valid10); end
        load10(9, 9);
        n_checks++; if (valid10 !== 1'b1 || max10 !== MAX10) begin n_errors++; $display("FAIL gap_valid_latency: got v=%b max %h required 1 %h", valid10, max10, MAX10); end
        while (idx < 10) begin
            n_checks++; if (dout10 !== cur10[idx]) begin n_errors++; $display("FAIL gap_replay[%0d]: got %h required %h", idx, dout10, cur10[idx]); end
            idx++; tick();
        end
        tick();
    endtask

    task automatic test_mixed_sign();
        int idx = 0;
        cur4 = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'h80000000};
        ready4 = 1'b1;
        load4();
        n_checks++; if (max4 !== 32'h80000000 || valid4 !== 1'b1) begin n_errors++; $display("FAIL mixed_max: got %h v=%b required 80000000 v=1", max4, valid4); end
        // Junk word held on start during replay and DONE must be dropped.
        start4 = 1'b1; data4 = 32'h7F000000;
        while (idx < 4) begin
            n_checks++; if (dout4 !== cur4[idx]) begin n_errors++; $display("FAIL mixed_replay[%0d]: got %h required %h", idx, dout4, cur4[idx]); end
            idx++; tick();
        end
        n_checks++; if (done4 !== 1'b1) begin n_errors++; $display("FAIL mixed_done: got %b required 1", done4); end
        tick();
        n_checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0) begin n_errors++; $display("FAIL mixed_ignore_start: got busy=%b v=%b required 0 0", busy4, valid4); end
        start4 = 1'b0;
        tick();
    endtask

    task automatic test_zero_tie();
        int idx = 0;
        cur4 = '{32'h00000000, 32'h80000000, 32'hC0000000, 32'h80000000};
        load4();
        n_checks++; if (max4 !== 32'h00000000) begin n_errors++; $display("FAIL tie_max: got %h required 00000000", max4); end
        while (idx < 4) begin
            n_checks++; if (dout4 !== cur4[idx]) begin n_errors++; $display("FAIL tie_replay[%0d]: got %h required %h", idx, dout4, cur4[idx]); end
            idx++; tick();
        end
        tick();
    endtask

    task automatic test_reset_mid_replay();
        int idx = 0;
        cur10 = w10; ready10 = 1'b1;
        load10(0, 9);
        while (idx < 5) begin idx++; tick(); end
        n_checks++; if (dout10 !== cur10[5]) begin n_errors++; $display("FAIL rstmid_pre: got %h required %h", dout10, cur10[5]); end
        rst = 1'b1; start10 = 1'b1; data10 = 32'h3F800000;
        tick();
        rst = 1'b0; start10 = 1'b0;
        n_checks++; if ({valid10, busy10, done10, err10, dout10, max10} !== 68'h0) begin n_errors++; $display("FAIL rstmid_outputs: got %b %h %h required all 0", {valid10, busy10, done10, err10}, dout10, max10); end
        for (int i = 0; i < 10; i++) cur10[i] = w10[9 - i];
        load10(0, 9);
        n_checks++; if (max10 !== MAX10 || valid10 !== 1'b1) begin n_errors++; $display("FAIL rstmid_new_max: got %h v=%b required %h v=1", max10, valid10, MAX10); end
        idx = 0;
        while (idx < 10) begin
            n_checks++; if (dout10 !== cur10[idx]) begin n_errors++; $display("FAIL rstmid_replay[%0d]: got %h required %h", idx, dout10, cur10[idx]); end
            idx++; tick();
        end
        n_checks++; if (done10 !== 1'b1) begin n_errors++; $display("FAIL rstmid_done: got %b required 1", done10); end
        tick();
    endtask

    task automatic test_nan_detect();
        cur10 = w10; cur10[2] = 32'h7FC00000; ready10 = 1'b1;
        load10(0, 1);
        n_checks++; if (err10 !== 1'b0) begin n_errors++; $display("FAIL nan_before: got %b required 0", err10); end
        load10(2, 2);
        n_checks++; if (err10 !== EXP_ERR) begin n_errors++; $display("FAIL nan_after_capture: got %b required %b", err10, EXP_ERR); end
        load10(3, 9);
        n_checks++; if (max10 !== 32'h7FC00000) begin n_errors++; $display("FAIL nan_max: got %h required 7fc00000", max10); end
        repeat (11) tick();
        n_checks++; if (err10 !== EXP_ERR || busy10 !== 1'b0) begin n_errors++; $display("FAIL nan_sticky_idle: got err=%b busy=%b required %b 0", err10, busy10, EXP_ERR); end
        cur10 = w10;
        load10(0, 0);
        n_checks++; if (err10 !== 1'b0) begin n_errors++; $display("FAIL nan_clear_new_vector: got %b required 0", err10); end
        load10(1, 9);
        repeat (12) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start10 = 1'b0; ready10 = 1'b0; data10 = '0;
        start4 = 1'b0; ready4 = 1'b0; data4 = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_mixed_sign();
        test_zero_tie();
        test_reset_mid_replay();
        test_nan_detect();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/softmax_max_buffer.md
SOFTMAX_MAX_BUFFER -- requirements
Module: softmax_max_buffer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, meaning input/output word width (IEEE-754 single precision).
REQ-002 SHALL have parameter NUMBER_OF_DATA, default 10, meaning the number of words per softmax vector (range 2..256).
REQ-003 SHALL have port clock_i  input  1  meaning the single clock, rising edge.
REQ-004 SHALL have port reset_i  input  1  meaning the reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  meaning data_i holds a valid input word this cycle.
REQ-006 SHALL have port data_i  input  DATA_SIZE  meaning the input float word.
REQ-007 SHALL have port ready_i  input  1  meaning downstream (subtract/exp stage) accepts data_o this cycle.
REQ-008 SHALL have port data_valid_o  output  1  meaning data_o and max_o are valid for downstream.
REQ-009 SHALL have port data_o  output  DATA_SIZE  meaning the buffered input word, replayed in arrival order.
REQ-010 SHALL have port max_o  output  DATA_SIZE  meaning the maximum of the current vector.
REQ-011 SHALL have port busy_o  output  1  meaning the state is not IDLE.
REQ-012 SHALL have port done_o  output  1  meaning a one-cycle pulse after the last word is accepted.
REQ-013 SHALL have port error_o  output  1  meaning a sticky flag that a NaN or Inf word was seen in the current vector.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, REPLAY and DONE.
REQ-015 IDLE with start_i=1 SHALL write data_i to buffer[0], set the running max to data_i, set the count to 1 and go to LOAD.
REQ-016 LOAD with start_i=1 SHALL write data_i to buffer[count], update the running max and increment the count.
REQ-017 LOAD with start_i=0 SHALL hold all state (gaps allowed, nothing captured).
REQ-018 When the NUMBER_OF_DATA-th word is captured, the next state SHALL be REPLAY; max_o SHALL be final and stable on the first REPLAY cycle.
REQ-019 Latency: data_valid_o SHALL rise exactly one cycle after the clock edge that captures the last word.
REQ-020 The max compare SHALL use sign-magnitude order: positive beats negative; both positive means the larger bits[30:0] wins; both negative means the smaller bits[30:0] wins.
REQ-021 The max compare SHALL treat -0 and +0 as equal, and a tie SHALL keep the earlier word.
REQ-022 In REPLAY, data_valid_o SHALL be 1 and data_o SHALL equal buffer[rd_ptr]; rd_ptr SHALL advance only when data_valid_o && ready_i.
REQ-023 When ready_i=0, data_o, max_o and data_valid_o SHALL be held unchanged.
REQ-024 When the last word is accepted, the FSM SHALL go to DONE; in DONE, done_o=1 and data_valid_o=0 for one cycle, then IDLE.
REQ-025 start_i SHALL be ignored in REPLAY and DONE; a word presented then is dropped, not buffered.
REQ-026 In IDLE, data_o and max_o SHALL hold their last values and data_valid_o SHALL be 0.
REQ-027 All outputs SHALL be driven from registers only, with no combinational path from any input to any output.
REQ-028 The count and rd_ptr SHALL be $clog2(NUMBER_OF_DATA+1) bits wide and SHALL never wrap past NUMBER_OF_DATA.

Reset
REQ-029 When reset_i=1 at a clock edge, the state SHALL become IDLE, count and rd_ptr SHALL become 0, and data_valid_o, busy_o, done_o, error_o, data_o and max_o SHALL become 0.
REQ-030 Reset mid-LOAD or mid-REPLAY SHALL abandon the vector; buffer contents are don't-care after reset.
REQ-031 reset_i SHALL take priority over start_i and ready_i in the same cycle.

Configuration
REQ-032 With macro SOFTMAX_MAX_BUFFER_NAN_DETECT_EN defined, error_o SHALL be set whenever a captured word has exponent 8'hFF; error_o SHALL clear on the IDLE-to-LOAD transition and on reset.
REQ-033 Without SOFTMAX_MAX_BUFFER_NAN_DETECT_EN, error_o SHALL be tied to 0, and exponent-8'hFF words SHALL be compared as ordinary bits.

Verification
REQ-034 Ten words are streamed back to back with ready_i=1: 0x40AB0A3D, 0x418A49BA, 0x4158C8B4, 0x41A0ED91, 0x40B5FBE7, 0x40FE872B, 0x41035810, 0x4166B020, 0x4184126E, 0x3E1CAC08. Response: max_o=0x41A0ED91 (20.116), the ten words replay in order over 10 cycles, then done_o pulses.
REQ-035 Mixed-sign vector with NUMBER_OF_DATA=4: 0xBF800000, 0xBF000000, 0xC0000000, 0x80000000 (-1, -0.5, -2, -0). Response: max_o=0x80000000.
REQ-036 Backpressure: ready_i=0 for 3 cycles at replay index 2. Response: data_o is held at word 2 for 4 cycles, no word is lost or duplicated, and the total replay takes 13 cycles.
REQ-037 Gapped input: start_i=0 for 2 cycles after word 4. Response: all 10 words are captured, and data_valid_o rises 1 cycle after word 10.
REQ-038 Reset asserted during replay index 5. Response: the next cycle is IDLE with all outputs 0, and a new vector then processes correctly.
REQ-039 With the macro defined, word 3 = 0x7FC00000. Response: error_o=1 from the cycle after capture until the next vector starts.
